// File: rtl/predictor_phase_sequencer.sv
// Phase sequencer for the predictor datapath: emits a one-hot trigger train with a
// programmable per-phase dwell, continuous or one-shot frames, stall and frame counting.
module predictor_phase_sequencer #(
  parameter int unsigned NUM_PHASES  = 4,
  parameter int unsigned DWELL_W     = 4,
  parameter int unsigned FRAME_CNT_W = 16,
  localparam int unsigned PHASE_W    = (NUM_PHASES > 2) ? $clog2(NUM_PHASES) : 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          one_shot,
  input  logic                          start,
  input  logic                          stall,
  input  logic [NUM_PHASES*DWELL_W-1:0] dwell,
  output logic [NUM_PHASES-1:0]         trigger,
  output logic [PHASE_W-1:0]            phase,
  output logic                          busy,
  output logic                          frame_done,
  output logic [FRAME_CNT_W-1:0]        frame_count
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  localparam logic [PHASE_W-1:0]    LastPhase = PHASE_W'(NUM_PHASES - 1);
  localparam logic [NUM_PHASES-1:0] FirstTrig = NUM_PHASES'(1);

  state_e               state_q;
  logic [DWELL_W-1:0]   cnt_q;
  logic [DWELL_W-1:0]   dwell_arr [NUM_PHASES];
  logic [PHASE_W-1:0]   phase_inc;

  always_comb begin
    for (int k = 0; k < NUM_PHASES; k++) begin
      dwell_arr[k] = dwell[k*DWELL_W +: DWELL_W];
    end
  end

  assign phase_inc = phase + PHASE_W'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      trigger     <= '0;
      phase       <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_done <= 1'b0;
      // A stalled edge changes nothing; a start seen while stalled is simply lost.
      if (!stall) begin
        unique case (state_q)
          StIdle: begin
            if (enable && (!one_shot || start)) begin
              state_q <= StRun;
              phase   <= '0;
              cnt_q   <= dwell_arr[0];
              trigger <= FirstTrig;
              busy    <= 1'b1;
            end
          end
          StRun: begin
            if (cnt_q != '0) begin
              cnt_q <= cnt_q - DWELL_W'(1);
            end else if (phase != LastPhase) begin
              phase   <= phase_inc;
              cnt_q   <= dwell_arr[phase_inc];
              trigger <= trigger << 1;
            end else begin
              frame_done  <= 1'b1;
              frame_count <= frame_count + FRAME_CNT_W'(1);
              // Mode and enable are only consulted here, so a frame is never cut short.
              if (enable && !one_shot) begin
                phase   <= '0;
                cnt_q   <= dwell_arr[0];
                trigger <= FirstTrig;
              end else begin
                state_q <= StIdle;
                phase   <= '0;
                trigger <= '0;
                busy    <= 1'b0;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_predictor_phase_sequencer.sv
// Directed self-checking bench for predictor_phase_sequencer; a second instance with a
// 2-bit frame counter shares the stimulus to exercise counter wrap.
module tb_predictor_phase_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable, one_shot, start, stall;
  logic [15:0] dwell;
  logic [3:0]  trigger, trigger_w;
  logic [1:0]  phase, phase_w;
  logic        busy, busy_w, frame_done, frame_done_w;
  logic [15:0] frame_count;
  logic [1:0]  frame_count_w;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  predictor_phase_sequencer #(.NUM_PHASES(4), .DWELL_W(4), .FRAME_CNT_W(16)) dut (
    .clock(clock), .reset(reset), .enable(enable), .one_shot(one_shot), .start(start),
    .stall(stall), .dwell(dwell), .trigger(trigger), .phase(phase), .busy(busy),
    .frame_done(frame_done), .frame_count(frame_count)
  );

  predictor_phase_sequencer #(.NUM_PHASES(4), .DWELL_W(4), .FRAME_CNT_W(2)) dut_w (
    .clock(clock), .reset(reset), .enable(enable), .one_shot(one_shot), .start(start),
    .stall(stall), .dwell(dwell), .trigger(trigger_w), .phase(phase_w), .busy(busy_w),
    .frame_done(frame_done_w), .frame_count(frame_count_w)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; enable = 1'b0; one_shot = 1'b0; start = 1'b0; stall = 1'b0; dwell = '0;
    step(); step(); step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if ({trigger, phase, busy, frame_done, frame_count} !== '0) begin
      bad++;
      $display("FAIL reset: got trig=%b ph=%0d busy=%b fd=%b cnt=%0d want all 0",
               trigger, phase, busy, frame_done, frame_count);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] exp_tr;
    enable = 1'b1;
    for (int i = 0; i <= 12; i++) begin
      step();
      exp_tr = 4'b0001 << (i % 4);
      total++;
      if (trigger !== exp_tr || phase !== 2'(i % 4) || busy !== 1'b1) begin
        bad++;
        $display("FAIL rotation[%0d]: got trig=%b ph=%0d busy=%b want trig=%b ph=%0d busy=1",
                 i, trigger, phase, busy, exp_tr, i % 4);
      end
      total++;
      if (frame_done !== (i % 4 == 0 && i > 0) || frame_count !== 16'(i / 4)) begin
        bad++;
        $display("FAIL rotation_done[%0d]: got fd=%b cnt=%0d want fd=%b cnt=%0d",
                 i, frame_done, frame_count, (i % 4 == 0 && i > 0), i / 4);
      end
    end
  endtask

  task automatic test_dwell();
    logic [3:0] exp_tr [10] = '{4'h1, 4'h1, 4'h2, 4'h2, 4'h2, 4'h4, 4'h8, 4'h8, 4'h8, 4'h8};
    apply_reset();
    dwell = 16'h3021;
    enable = 1'b1; one_shot = 1'b1; start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      start = 1'b0;
      total++;
      if (trigger !== exp_tr[i] || busy !== 1'b1 || frame_done !== 1'b0) begin
        bad++;
        $display("FAIL dwell[%0d]: got trig=%b busy=%b fd=%b want trig=%b busy=1 fd=0",
                 i, trigger, busy, frame_done, exp_tr[i]);
      end
    end
    step();
    total++;
    if (trigger !== 4'b0 || busy !== 1'b0 || frame_done !== 1'b1 || frame_count !== 16'd1) begin
      bad++;
      $display("FAIL dwell_end: got trig=%b busy=%b fd=%b cnt=%0d want 0000 0 1 1",
               trigger, busy, frame_done, frame_count);
    end
  endtask

  task automatic test_one_shot();
    logic [3:0] exp_tr [4] = '{4'h1, 4'h2, 4'h4, 4'h8};
    apply_reset();
    enable = 1'b1; one_shot = 1'b1;
    step();
    total++;
    if (trigger !== 4'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL oneshot_wait: got trig=%b busy=%b want 0000 0", trigger, busy);
    end
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      start = (i == 1);  // second start lands mid-frame
      total++;
      if (trigger !== exp_tr[i] || busy !== 1'b1 || frame_done !== 1'b0) begin
        bad++;
        $display("FAIL oneshot[%0d]: got trig=%b busy=%b fd=%b want trig=%b busy=1 fd=0",
                 i, trigger, busy, frame_done, exp_tr[i]);
      end
    end
    step();
    total++;
    if (trigger !== 4'b0 || busy !== 1'b0 || frame_done !== 1'b1 || frame_count !== 16'd1) begin
      bad++;
      $display("FAIL oneshot_end: got trig=%b busy=%b fd=%b cnt=%0d want 0000 0 1 1",
               trigger, busy, frame_done, frame_count);
    end
    step(); step();
    total++;
    if (trigger !== 4'b0 || busy !== 1'b0 || frame_done !== 1'b0 || frame_count !== 16'd1) begin
      bad++;
      $display("FAIL oneshot_idle: got trig=%b busy=%b fd=%b cnt=%0d want 0000 0 0 1",
               trigger, busy, frame_done, frame_count);
    end
  endtask

  task automatic test_stall();
    apply_reset();
    enable = 1'b1;
    step(); step(); step();
    total++;
    if (trigger !== 4'b0100 || phase !== 2'd2) begin
      bad++;
      $display("FAIL stall_pre: got trig=%b ph=%0d want 0100 2", trigger, phase);
    end
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (trigger !== 4'b0100 || phase !== 2'd2 || busy !== 1'b1) begin
        bad++;
        $display("FAIL stall_hold[%0d]: got trig=%b ph=%0d busy=%b want 0100 2 1",
                 i, trigger, phase, busy);
      end
    end
    stall = 1'b0;
    step();
    total++;
    if (trigger !== 4'b1000 || phase !== 2'd3) begin
      bad++;
      $display("FAIL stall_release: got trig=%b ph=%0d want 1000 3", trigger, phase);
    end
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if (trigger !== 4'b1000 || frame_done !== 1'b0 || frame_count !== 16'd0) begin
        bad++;
        $display("FAIL stall_boundary[%0d]: got trig=%b fd=%b cnt=%0d want 1000 0 0",
                 i, trigger, frame_done, frame_count);
      end
    end
    stall = 1'b0;
    step();
    total++;
    if (trigger !== 4'b0001 || frame_done !== 1'b1 || frame_count !== 16'd1) begin
      bad++;
      $display("FAIL stall_done: got trig=%b fd=%b cnt=%0d want 0001 1 1",
               trigger, frame_done, frame_count);
    end
    step();
    total++;
    if (trigger !== 4'b0010 || frame_done !== 1'b0) begin
      bad++;
      $display("FAIL stall_done_pulse: got trig=%b fd=%b want 0010 0", trigger, frame_done);
    end
  endtask

  task automatic test_stop_and_reset();
    logic [3:0] exp_tr [3] = '{4'h4, 4'h8, 4'h0};
    apply_reset();
    enable = 1'b1;
    step(); step();
    enable = 1'b0;  // dropped during phase 1
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (trigger !== exp_tr[i] || frame_done !== (i == 2) || busy !== (i != 2)) begin
        bad++;
        $display("FAIL stop[%0d]: got trig=%b fd=%b busy=%b want trig=%b fd=%b busy=%b",
                 i, trigger, frame_done, busy, exp_tr[i], i == 2, i != 2);
      end
    end
    step();
    total++;
    if (trigger !== 4'b0 || busy !== 1'b0 || frame_done !== 1'b0 || frame_count !== 16'd1) begin
      bad++;
      $display("FAIL stop_idle: got trig=%b busy=%b fd=%b cnt=%0d want 0000 0 0 1",
               trigger, busy, frame_done, frame_count);
    end
    enable = 1'b1;
    step(); step(); step();
    total++;
    if (trigger !== 4'b0100 || phase !== 2'd2) begin
      bad++;
      $display("FAIL restart: got trig=%b ph=%0d want 0100 2", trigger, phase);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if (trigger !== 4'b0 || phase !== 2'd0 || busy !== 1'b0 || frame_count !== 16'd0) begin
      bad++;
      $display("FAIL async_reset: got trig=%b ph=%0d busy=%b cnt=%0d want 0000 0 0 0",
               trigger, phase, busy, frame_count);
    end
    step();
    reset = 1'b0;
    step();
    total++;
    if (trigger !== 4'b0001 || busy !== 1'b1) begin
      bad++;
      $display("FAIL post_reset: got trig=%b busy=%b want 0001 1", trigger, busy);
    end
  endtask

  task automatic test_wrap();
    logic [1:0] exp_w [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    apply_reset();
    enable = 1'b1;
    for (int i = 0; i <= 20; i++) begin
      step();
      if (i % 4 == 0 && i > 0) begin
        total++;
        if (frame_count_w !== exp_w[i/4-1] || frame_done_w !== 1'b1) begin
          bad++;
          $display("FAIL wrap[%0d]: got cnt=%0d fd=%b want cnt=%0d fd=1",
                   i / 4, frame_count_w, frame_done_w, exp_w[i/4-1]);
        end
      end
    end
    total++;
    if (frame_count !== 16'd5) begin
      bad++;
      $display("FAIL wide_count: got %0d want 5", frame_count);
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_dwell();
    test_one_shot();
    test_stall();
    test_stop_and_reset();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
